sbox_share_sched: RTL

Time-multiplexes one bank of four forward AES S-box lanes between two requesters: the key-expansion SubWord path (32-bit words) and the round SubBytes path (128-bit states). Each 128-bit state is processed as four 32-bit word slots. Key words are interleaved between block slots under a fairness rule. Results are registered and held under valid/ready handshakes. The block sits between the round controller and the key scheduler and replaces their private S-box copies.

---
 rtl/sbox_share_pkg.sv | 29 ++
 rtl/forward_substitution_box.sv | 41 ++++
 rtl/sbox_lane_bank.sv | 27 ++
 rtl/sbox_share_sched.sv | 117 +++++++++++
 4 files changed

// File: rtl/sbox_share_pkg.sv
// ============================================================================
// sbox_share_pkg : shared constants and FSM encoding for the S-box scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package sbox_share_pkg;

  localparam int LANES  = 4;
  localparam int WORDS  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = LANES * BYTE_W;
  localparam int BLK_W  = WORDS * WORD_W;
  localparam int WC_W   = 2;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_RUN  = 2'd1,
    B_DONE = 2'd2
  } bstate_e;

  // Bit offset of 32-bit word slot idx inside a 128-bit state
  function automatic logic [6:0] word_lsb(input logic [WC_W-1:0] idx);
    return {idx, 5'b00000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/forward_substitution_box.sv
// ============================================================================
// FORWARD_SUBSTITUTION_BOX : combinational forward AES S-box lookup, one byte
// Revision: 1.0
// ============================================================================
`default_nettype none

module FORWARD_SUBSTITUTION_BOX (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry x sits at bits [8*(255-x) +: 8]
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic unused_pins;
  assign unused_pins = clk ^ rst;

  assign dout = SBOX[{~din, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: rtl/sbox_lane_bank.sv
// ============================================================================
// sbox_lane_bank : four parallel byte S-box lanes, 32-bit word in and out
// Revision: 1.0
// ============================================================================
`default_nettype none

module sbox_lane_bank
  import sbox_share_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    FORWARD_SUBSTITUTION_BOX u_sbox (
      .clk  (clk),
      .rst  (rst),
      .din  (din[i*BYTE_W +: BYTE_W]),
      .dout (dout[i*BYTE_W +: BYTE_W])
    );
  end

endmodule

`default_nettype wire

// File: rtl/sbox_share_sched.sv
// ============================================================================
// sbox_share_sched : shares one 4-lane S-box bank between key SubWord and
//                    round SubBytes requesters with a key/block fairness rule
// Revision: 1.0
// ============================================================================
`default_nettype none

module sbox_share_sched
  import sbox_share_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_in_valid,
  output logic              key_in_ready,
  input  logic [WORD_W-1:0] key_in_word,
  output logic              key_out_valid,
  input  logic              key_out_ready,
  output logic [WORD_W-1:0] key_out_word,
  input  logic              blk_in_valid,
  output logic              blk_in_ready,
  input  logic [BLK_W-1:0]  blk_in_data,
  output logic              blk_out_valid,
  input  logic              blk_out_ready,
  output logic [BLK_W-1:0]  blk_out_data,
  output logic              busy
);

  bstate_e           r_state;
  logic [WC_W-1:0]   r_wc;
  logic              r_last_key;
  logic [BLK_W-1:0]  r_hold;

  logic              w_key_buf_free;
  logic              w_key_grant;
  logic              w_blk_slot;
  logic              w_blk_accept;
  logic [WORD_W-1:0] w_lane_in;
  logic [WORD_W-1:0] w_lane_out;

  // A key slot right after another key slot is refused while a block runs
  always_comb begin
    w_key_buf_free = !key_out_valid || key_out_ready;
    w_key_grant    = key_in_valid && w_key_buf_free &&
                     !((r_state == B_RUN) && r_last_key);
    w_blk_slot     = (r_state == B_RUN) && !w_key_grant;
    w_blk_accept   = blk_in_valid && blk_in_ready;
    w_lane_in      = w_key_grant ? key_in_word : r_hold[word_lsb(r_wc) +: WORD_W];
  end

  assign key_in_ready  = rst && w_key_grant;
  assign blk_in_ready  = rst && ((r_state == B_IDLE) ||
                                 ((r_state == B_DONE) && blk_out_ready));
  assign blk_out_valid = (r_state == B_DONE);
  assign busy          = (r_state != B_IDLE) || key_out_valid;

  sbox_lane_bank u_lanes (
    .clk  (clk),
    .rst  (rst),
    .din  (w_lane_in),
    .dout (w_lane_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= B_IDLE;
      r_wc          <= '0;
      r_last_key    <= 1'b0;
      r_hold        <= '0;
      key_out_valid <= 1'b0;
      key_out_word  <= '0;
      blk_out_data  <= '0;
    end else begin
      r_last_key <= w_key_grant;

      if (w_key_grant) begin
        key_out_word  <= w_lane_out;
        key_out_valid <= 1'b1;
      end else if (key_out_ready) begin
        key_out_valid <= 1'b0;
      end

      case (r_state)
        B_IDLE: begin
          if (w_blk_accept) begin
            r_hold  <= blk_in_data;
            r_wc    <= '0;
            r_state <= B_RUN;
          end
        end
        B_RUN: begin
          if (w_blk_slot) begin
            blk_out_data[word_lsb(r_wc) +: WORD_W] <= w_lane_out;
            r_wc <= r_wc + 2'd1;
            if (r_wc == 2'd3) begin
              r_state <= B_DONE;
            end
          end
        end
        B_DONE: begin
          if (blk_out_ready) begin
            if (blk_in_valid) begin
              r_hold  <= blk_in_data;
              r_wc    <= '0;
              r_state <= B_RUN;
            end else begin
              r_state <= B_IDLE;
            end
          end
        end
        default: r_state <= B_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
